// File: rtl/hc595_chain_driver.sv
// Request-driven serial driver for a daisy chain of 74HC595 shift registers.
// Each accepted frame is shifted out once, latched, and reported with Done; one frame may queue behind it.
module hc595_chain_driver #(
  parameter int CHAIN_LEN = 2,
  parameter int DIV       = 5,
  parameter int LSB_FIRST = 0
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [8*CHAIN_LEN-1:0] Data,
  input  logic                   Send,
  input  logic                   Blank,
  output logic                   Busy,
  output logic                   Pending,
  output logic                   Done,
  output logic                   SH_CP,
  output logic                   ST_CP,
  output logic                   DS,
  output logic                   OE_N
);

  localparam int              W        = 8 * CHAIN_LEN;
  localparam int              BW       = $clog2(W);
  localparam logic [15:0]     DIV_LAST = 16'(DIV - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  state_e          state_q;
  logic [15:0]     cnt_q;
  logic [BW-1:0]   bitcnt_q;
  logic [W-1:0]    shreg_q;
  logic [W-1:0]    pend_q;
  logic            pending_q;
  logic            busy_q;
  logic            done_q;
  logic            sh_cp_q;
  logic            st_cp_q;
  logic            ds_q;
  logic            oe_n_q;
  logic            first_latch_q;

  logic            tick;
  logic [W-1:0]    shreg_d;
  logic [W-1:0]    load_d;

  // The bit that sits at the output end of a frame is the one driven on DS.
  function automatic logic out_bit(input logic [W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[W-1];
  endfunction

  assign tick    = (cnt_q == DIV_LAST);
  assign shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
  // A request arriving on the final latch tick beats anything already queued.
  assign load_d  = Send ? Data : pend_q;

  // NOTE: every register here, including the pending frame buffer, is cleared
  // by reset and updated with non-blocking assignments so all state moves on
  // the same edge regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      shreg_q       <= '0;
      pend_q        <= '0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sh_cp_q       <= 1'b0;
      st_cp_q       <= 1'b0;
      ds_q          <= 1'b0;
      oe_n_q        <= 1'b1;
      first_latch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      oe_n_q <= first_latch_q ? Blank : 1'b1;

      if (state_q != IDLE) begin
        cnt_q <= tick ? '0 : cnt_q + 16'd1;
      end

      // Requests while busy land in the one-deep buffer, latest wins.
      if (state_q != IDLE && Send) begin
        pend_q    <= Data;
        pending_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (Send) begin
            state_q  <= SHIFT;
            shreg_q  <= Data;
            ds_q     <= out_bit(Data);
            bitcnt_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            sh_cp_q  <= 1'b0;
          end
        end

        SHIFT: begin
          if (tick) begin
            if (!sh_cp_q) begin
              sh_cp_q <= 1'b1;
            end else begin
              sh_cp_q <= 1'b0;
              if (bitcnt_q == LAST_BIT) begin
                state_q <= LATCH;
              end else begin
                bitcnt_q <= bitcnt_q + 1'b1;
                shreg_q  <= shreg_d;
                ds_q     <= out_bit(shreg_d);
              end
            end
          end
        end

        LATCH: begin
          if (tick) begin
            if (!st_cp_q) begin
              st_cp_q <= 1'b1;
            end else begin
              st_cp_q       <= 1'b0;
              done_q        <= 1'b1;
              first_latch_q <= 1'b1;
              if (Send || pending_q) begin
                state_q   <= SHIFT;
                shreg_q   <= load_d;
                ds_q      <= out_bit(load_d);
                bitcnt_q  <= '0;
                pending_q <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Pending = pending_q;
  assign Done    = done_q;
  assign SH_CP   = sh_cp_q;
  assign ST_CP   = st_cp_q;
  assign DS      = ds_q;
  assign OE_N    = oe_n_q;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: a time-based frame model checks the main instance every cycle,
// and two small extra instances cover LSB-first ordering and the fastest divider.
module tb_hc595_chain_driver;

  localparam int CL     = 2;
  localparam int DIV    = 5;
  localparam int W      = 8 * CL;
  localparam int PERIOD = (2 * W + 2) * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: CHAIN_LEN=2, DIV=5, MSB first
  logic [W-1:0] data = '0;
  logic send = 1'b0, blank = 1'b0;
  logic busy, pending, done, sh, st, ds, oe_n;

  // LSB-first instance
  logic [15:0] data_l = '0;
  logic send_l = 1'b0;
  logic busy_l, pending_l, done_l, sh_l, st_l, ds_l, oe_l;

  // Single-device, DIV=1 instance
  logic [7:0] data_d = '0;
  logic send_d = 1'b0;
  logic busy_d, pending_d, done_d, sh_d, st_d, ds_d, oe_d;

  hc595_chain_driver #(.CHAIN_LEN(CL), .DIV(DIV), .LSB_FIRST(0)) dut (
    .Clk(clk), .Rst_n(rst_n), .Data(data), .Send(send), .Blank(blank),
    .Busy(busy), .Pending(pending), .Done(done), .SH_CP(sh), .ST_CP(st),
    .DS(ds), .OE_N(oe_n));

  hc595_chain_driver #(.CHAIN_LEN(2), .DIV(5), .LSB_FIRST(1)) dut_lsb (
    .Clk(clk), .Rst_n(rst_n), .Data(data_l), .Send(send_l), .Blank(1'b0),
    .Busy(busy_l), .Pending(pending_l), .Done(done_l), .SH_CP(sh_l), .ST_CP(st_l),
    .DS(ds_l), .OE_N(oe_l));

  hc595_chain_driver #(.CHAIN_LEN(1), .DIV(1), .LSB_FIRST(0)) dut_d1 (
    .Clk(clk), .Rst_n(rst_n), .Data(data_d), .Send(send_d), .Blank(1'b0),
    .Busy(busy_d), .Pending(pending_d), .Done(done_d), .SH_CP(sh_d), .ST_CP(st_d),
    .DS(ds_d), .OE_N(oe_d));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a frame is described by its data and the number of
  // cycles elapsed since it was loaded; outputs follow from that time alone.
  int          m_t;
  logic        m_busy, m_pv, m_first, m_oe, m_done;
  logic [W-1:0] m_frame, m_pd;

  function automatic logic bit_at(input logic [W-1:0] f, input int j);
    logic [W-1:0] v;
    v = f;
    return v[W-1-j];
  endfunction

  task automatic model_reset();
    m_t = 0; m_busy = 0; m_pv = 0; m_first = 0; m_oe = 1; m_done = 0;
    m_frame = '0; m_pd = '0;
  endtask

  task automatic model_step();
    m_oe   = m_first ? blank : 1'b1;
    m_done = 0;
    if (!m_busy) begin
      if (send) begin
        m_frame = data; m_t = 0; m_busy = 1;
      end
    end else begin
      m_t++;
      if (m_t == PERIOD) begin
        m_done = 1; m_first = 1;
        if (send || m_pv) begin
          m_frame = send ? data : m_pd;
          m_pv = 0; m_t = 0;
        end else begin
          m_busy = 0;
        end
      end else if (send) begin
        m_pv = 1; m_pd = data;
      end
    end
  endtask

  task automatic compare();
    int   half;
    logic e_sh, e_st, e_ds;
    if (!m_busy) begin
      e_sh = 0; e_st = 0; e_ds = bit_at(m_frame, W - 1);
    end else begin
      half = m_t / DIV;
      if (half < 2 * W) begin
        e_sh = half[0]; e_st = 0; e_ds = bit_at(m_frame, half / 2);
      end else begin
        e_sh = 0; e_st = (half == 2 * W + 1); e_ds = bit_at(m_frame, W - 1);
      end
    end
    check("busy", busy, m_busy);
    check("pending", pending, m_pv);
    check("done", done, m_done);
    check("sh_cp", sh, e_sh);
    check("st_cp", st, e_st);
    check("ds", ds, e_ds);
    check("oe_n", oe_n, m_oe);
  endtask

  // Monitor: reconstructs frames as a 595 chain would see them.
  logic [W-1:0] fbits;
  int           frises, st_w, done_cnt, done_cyc, first_rise_cyc;
  logic         p_sh, p_st;
  logic [W-1:0] frames[$];
  int           frame_rises[$];

  initial begin
    fbits = '0; frises = 0; st_w = 0; done_cnt = 0; done_cyc = 0; first_rise_cyc = 0;
    p_sh = 0; p_st = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        frises = 0; st_w = 0; p_sh = 0; p_st = 0;
      end else begin
        model_step();
        compare();
        if (sh && !p_sh) begin
          fbits = {fbits[W-2:0], ds};
          frises++;
          if (frises == 1) first_rise_cyc = cyc;
        end
        if (st && !p_st) begin
          frames.push_back(fbits);
          frame_rises.push_back(frises);
          frises = 0; st_w = 0;
        end
        if (st) st_w++;
        if (done) begin
          done_cnt++; done_cyc = cyc;
        end
        p_sh = sh; p_st = st;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, output int acc);
    send = 1; data = d; acc = cyc + 1;
    step();
    send = 0; data = W'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0, i;
    n0 = done_cnt; i = 0;
    while (done_cnt == n0 && i < budget) begin
      step();
      i++;
    end
    check(name, done_cnt - n0, 1);
  endtask

  initial begin
    int acc, d1, nf, i, bc, nr;
    logic seen, p;
    logic [15:0] bits;

    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sh", sh, 0);
    check("rst_st", st, 0);
    check("rst_ds", ds, 0);
    check("rst_pending", pending, 0);
    check("rst_oe_n", oe_n, 1);
    rst_n = 1;
    repeat (2) step();

    // Single frame, literal expectations
    send_frame(16'hA5C3, acc);
    wait_done("a5c3_done_timeout", 400);
    check("a5c3_latency", done_cyc - acc, 170);
    check("a5c3_bits", frames[$], 16'hA5C3);
    check("a5c3_rises", frame_rises[$], 16);
    check("a5c3_st_width", st_w, 5);
    check("a5c3_oe_before", oe_n, 1);
    step();
    check("a5c3_oe_after", oe_n, 0);
    repeat (5) step();

    // Back-to-back with pending overwrite
    nf = frames.size();
    send_frame(16'h1111, acc);
    repeat (20) step();
    send_frame(16'h2222, acc);
    check("pend_after_2222", pending, 1);
    repeat (20) step();
    send_frame(16'h3333, acc);
    check("pend_after_3333", pending, 1);
    wait_done("b2b_done1_timeout", 400);
    d1 = done_cyc;
    check("pend_cleared_at_load", pending, 0);
    check("busy_no_gap", busy, 1);
    wait_done("b2b_done2_timeout", 400);
    check("b2b_count", frames.size() - nf, 2);
    check("b2b_frame0", frames[nf], 16'h1111);
    check("b2b_frame1", frames[nf+1], 16'h3333);
    check("b2b_gap", first_rise_cyc - d1, DIV);
    check("b2b_period", done_cyc - d1, PERIOD);
    repeat (5) step();

    // Blank control
    blank = 1;
    step();
    check("blank_oe_high", oe_n, 1);
    send_frame(16'h0F0F, acc);
    wait_done("blank_done_timeout", 400);
    check("blank_frame", frames[$], 16'h0F0F);
    check("blank_latency", done_cyc - acc, 170);
    blank = 0;
    step();
    check("unblank_oe_low", oe_n, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      send = ($urandom_range(0, 39) == 0);
      data = W'($urandom);
      if ($urandom_range(0, 299) == 0) blank = ~blank;
      step();
    end
    send = 0; blank = 0;
    i = 0;
    while ((busy || pending) && i < 800) begin
      step();
      i++;
    end
    check("random_drain", busy, 0);
    repeat (3) step();

    // Reset in the middle of a frame
    send_frame(16'hBEEF, acc);
    i = 0;
    while (frises < 8 && i < 400) begin
      step();
      i++;
    end
    check("reach_bit7", frises, 8);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sh", sh, 0);
    check("midrst_st", st, 0);
    check("midrst_ds", ds, 0);
    check("midrst_done", done, 0);
    check("midrst_oe_n", oe_n, 1);
    nf = done_cnt;
    repeat (2) step();
    rst_n = 1;
    repeat (200) step();
    check("midrst_no_done", done_cnt, nf);
    check("midrst_oe_still_high", oe_n, 1);
    send_frame(16'h5A5A, acc);
    wait_done("post_rst_done_timeout", 400);
    check("post_rst_latency", done_cyc - acc, 170);
    check("post_rst_frame", frames[$], 16'h5A5A);
    check("post_rst_oe_at_done", oe_n, 1);
    step();
    check("post_rst_oe_low", oe_n, 0);

    // LSB-first instance
    step();
    send_l = 1; data_l = 16'h0001;
    step();
    send_l = 0; data_l = 16'hFFFF;
    bits = '0; nr = 0; bc = 0; seen = 0; p = 0;
    for (int k = 0; k < 400; k++) begin
      if (busy_l) begin
        bc++; seen = 1;
      end
      if (sh_l && !p) begin
        bits = {bits[14:0], ds_l};
        nr++;
      end
      p = sh_l;
      if (seen && !busy_l) break;
      step();
    end
    check("lsb_finished", busy_l, 0);
    check("lsb_bits", bits, 16'h8000);
    check("lsb_rises", nr, 16);
    check("lsb_busy_cycles", bc, 170);

    // DIV=1 single-device instance
    step();
    send_d = 1; data_d = 8'hFF; acc = cyc + 1;
    step();
    send_d = 0; data_d = 8'h00;
    for (int k = 0; k < 16; k++) begin
      check("d1_sh_toggle", sh_d, k % 2);
      step();
    end
    i = 0;
    while (!done_d && i < 40) begin
      step();
      i++;
    end
    check("d1_done_seen", done_d, 1);
    check("d1_latency", cyc - acc, 18);
    check("d1_ds_last", ds_d, 1);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
Serial driver for a daisy-chain of CHAIN_LEN 74HC595 shift registers, such as segment/digit drivers or LED banks. It is request-driven, not free-running: each accepted frame is shifted out once and then latched, with Busy/Done handshaking and a one-deep pending buffer so back-to-back updates go out without gaps. It adds a configurable bit order and output-enable control that holds the chain blank until the first valid latch.

Parameters:
CHAIN_LEN, 2, number of cascaded 595 devices; frame width W = 8*CHAIN_LEN
DIV, 5, Clk cycles per SH_CP/ST_CP half-period; legal range 1..65535
LSB_FIRST, 0, 0 = Data[W-1] shifted first; 1 = Data[0] shifted first

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Data  in  W  frame to send, sampled on the cycle Send is accepted
Send  in  1  single-cycle request strobe
Blank  in  1  1 = force outputs off (OE_N high) after first latch
Busy  out  1  high while a frame is shifting or latching
Pending  out  1  high while a queued frame waits in the pending buffer
Done  out  1  one-Clk pulse when a frame's ST_CP falls
SH_CP  out  1  595 shift clock
ST_CP  out  1  595 storage/latch clock
DS  out  1  595 serial data
OE_N  out  1  595 output enable, active low

Behaviour:
- Reset (async): every output is 0 except OE_N = 1. The state machine returns to IDLE, all counters are cleared, the shift and pending registers are cleared, and the first-latch flag is cleared.
- Reset mid-frame: the frame is abandoned, outputs snap to reset values, and no Done is issued.
- Divider: cnt runs 0..DIV-1 only outside IDLE and is cleared on IDLE exit. tick = (cnt == DIV-1).
- States: IDLE, SHIFT, LATCH.
- IDLE, on Send:
  - shreg <= Data; DS <= first bit (Data[W-1], or Data[0] if LSB_FIRST).
  - bitcnt <= 0; Busy <= 1; go to SHIFT with SH_CP = 0.
- SHIFT, on tick with SH_CP = 0: SH_CP <= 1 (the 595 samples DS on this rising edge).
- SHIFT, on tick with SH_CP = 1: SH_CP <= 0, then:
  - If bitcnt == W-1: go to LATCH.
  - Otherwise: bitcnt++, shift shreg toward the output end, and DS <= next bit. DS changes only on SH_CP falling edges.
- LATCH:
  - First tick: ST_CP <= 1.
  - Second tick: ST_CP <= 0, Done <= 1 for one cycle, and the first-latch flag is set.
  - If Pending: load the pending frame exactly as IDLE does on Send (same edge), clear Pending, stay Busy, go to SHIFT.
  - Otherwise: Busy <= 0 and go to IDLE.
- DS holds the last bit during LATCH and IDLE. SH_CP stays 0 and ST_CP stays 0 except as described above.
- Latency: from the Send-accept edge to the Done edge is exactly (2W+2)*DIV Clk cycles. Back-to-back frames have period (2W+2)*DIV.
- Send while Busy: Data is captured into the pending register and Pending <= 1. If Pending is already 1, the new Data overwrites it (latest wins) and no error is raised.
- Send in the same cycle as the final LATCH tick with Pending = 0: the request is accepted into pending and starts immediately (same as the queued case). It is never dropped.
- Send in IDLE is accepted directly; Pending stays 0.
- OE_N:
  - Held at 1 until the first-latch flag is set.
  - Thereafter registered: OE_N <= Blank (one-cycle lag).
- Width rules: bitcnt is sized to ceil(log2(W)) bits; cnt is 16 bits.
- Data is ignored except at accept or capture.

Test Plan:
- Reset, then a single frame (CHAIN_LEN=2, DIV=5, LSB_FIRST=0, Data=16'hA5C3) -> 16 SH_CP rising edges. DS sampled at the rises reads 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. One ST_CP pulse 5 cycles wide. Done exactly 170 cycles after accept. OE_N falls 1 cycle after Done.
- LSB_FIRST=1, Data=16'h0001 -> first sampled bit is 1 and the rest are 0. Busy is high for exactly 170 cycles.
- Send 16'h1111, then Send 16'h2222 and 16'h3333 while Busy -> two frames total: 1111 then 3333. No IDLE gap: the second frame's first SH_CP rise comes DIV cycles after the first Done. Pending is high from the 2222 capture until the second frame loads.
- DIV=1, CHAIN_LEN=1, Data=8'hFF -> SH_CP toggles every cycle and Done arrives 18 cycles after accept.
- Assert Rst_n low at bit 7 of a frame -> all outputs go to reset values asynchronously with no Done. A fresh Send after release completes normally, and OE_N stays 1 until that frame's latch.
- Blank=1 after the first latch -> OE_N = 1 one cycle later. Shifting and latching continue unaffected. Blank=0 -> OE_N = 0.
